// File: rtl/mmio_out_fifo.sv
// Memory-mapped console output port: stores to DATA_ADDR enter a first-word-fall-through
// FIFO that drains to a valid/ready stream. STATUS_ADDR gives read status and a flush control.
module mmio_out_fifo #(
   parameter int              XLEN        = 64,
   parameter int              DEPTH       = 8,
   parameter logic [XLEN-1:0] DATA_ADDR   = 64'h0,
   parameter logic [XLEN-1:0] STATUS_ADDR = 64'h8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] io_out_addr,
   input  logic [XLEN-1:0] mem_out,
   input  logic            memory_we,
   output logic            mem_ready,
   input  logic [XLEN-1:0] io_in_addr,
   input  logic            memory_re,
   output logic [XLEN-1:0] mem_in_data,
   output logic            m_valid,
   output logic [XLEN-1:0] m_data,
   input  logic            m_ready,
   output logic [7:0]      fifo_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [XLEN-1:0] mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [31:0]     total_wr_q, total_wr_d;

   logic        hitd, flush, empty, full, pop, push;
   logic [63:0] status;

   assign hitd  = memory_we && (io_out_addr == DATA_ADDR);
   assign flush = memory_we && (io_out_addr == STATUS_ADDR) && mem_out[0];
   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == FULL_CNT);
   assign pop   = m_valid && m_ready;

   // A full FIFO still accepts a store when the host drains the head in the same cycle.
   assign mem_ready = !(hitd && full && !pop);
   assign push      = hitd && mem_ready;

   assign m_valid    = !empty;
   assign m_data     = mem_q[rd_ptr_q];
   assign fifo_count = 8'(cnt_q);

   assign status      = {total_wr_q, 22'd0, full, empty, 8'(cnt_q)};
   assign mem_in_data = (memory_re && (io_in_addr == STATUS_ADDR)) ? XLEN'(status) : '0;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      cnt_d      = cnt_q;
      total_wr_d = total_wr_q;
      if (flush) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         cnt_d      = '0;
         total_wr_d = '0;
      end else begin
         if (push) begin
            wr_ptr_d   = wr_ptr_q + PW'(1);
            total_wr_d = total_wr_q + 32'd1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         total_wr_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         total_wr_q <= total_wr_d;
      end
   end

   // Storage is never reset; stale entries are unreachable once the pointers clear.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= mem_out;
      end
   end

endmodule
